hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 48 ++++
 rtl/hazard_ctrl_loaduse_detect.sv | 25 ++
 rtl/hazard_ctrl.sv | 127 ++++++++++++
 tb/tb_hazard_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: state encodings,
// drain depth, counter widths and the pipeline-control bundle with its
// fixed per-mode values.
package hazard_ctrl_pkg;

  localparam int unsigned REG_W   = 3;
  localparam int unsigned STALL_W = 16;
  localparam int unsigned DCNT_W  = 2;

  localparam logic [DCNT_W-1:0]  DRAIN_DEPTH = DCNT_W'(3);
  localparam logic [STALL_W-1:0] STALL_MAX   = {STALL_W{1'b1}};

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DRAIN  = 2'b01,
    HALTED = 2'b10
  } state_e;

  // Pipeline register load/flush controls driven by the hazard unit.
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_flush;
    logic ex_mem_write;
    logic mem_wb_bubble;
  } pipe_ctrl_t;

  // Everything advances, nothing squashed.
  localparam pipe_ctrl_t CTRL_NORMAL = '{pc_write: 1'b1, if_id_write: 1'b1,
                                         if_id_flush: 1'b0, id_ex_write: 1'b1,
                                         id_ex_flush: 1'b0, ex_mem_write: 1'b1,
                                         mem_wb_bubble: 1'b0};

  // Whole pipeline frozen; WB sees a bubble so nothing retires twice.
  localparam pipe_ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, if_id_write: 1'b0,
                                         if_id_flush: 1'b0, id_ex_write: 1'b0,
                                         id_ex_flush: 1'b0, ex_mem_write: 1'b0,
                                         mem_wb_bubble: 1'b1};

  // Values held while rst is asserted: front of the pipe squashed, no retire.
  localparam pipe_ctrl_t CTRL_RESET  = '{pc_write: 1'b0, if_id_write: 1'b0,
                                         if_id_flush: 1'b1, id_ex_write: 1'b0,
                                         id_ex_flush: 1'b1, ex_mem_write: 1'b0,
                                         mem_wb_bubble: 1'b1};

endpackage

// File: rtl/hazard_ctrl_loaduse_detect.sv
// Purely combinational load-use hazard comparator.
// Ports: ID source registers and their use flags, ID_EX load/destination
// info in; hazard_c high when the ID instruction needs a load result that
// is still in EX.
module loaduse_detect
  import hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_write_reg,
  input  logic             ex_reg_write,
  output logic             hazard_c
);

  logic rs_match;
  logic rt_match;

  assign rs_match = id_rs_used && (id_rs == ex_write_reg);
  assign rt_match = id_rt_used && (id_rt == ex_write_reg);
  assign hazard_c = ex_mem_read && ex_reg_write && (rs_match || rt_match);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: resolves data-memory stalls, taken branches,
// load-use hazards, HALT draining and instruction-memory stalls into
// pipeline-register load/flush controls, and counts stall cycles.
// Ports: clk/rst; ID, EX, IF/MEM stall and WB halt status in; per-stage
// write/flush/bubble controls, halted flag and 16-bit stall_count out.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [REG_W-1:0]   id_rs,
  input  logic [REG_W-1:0]   id_rt,
  input  logic               id_rs_used,
  input  logic               id_rt_used,
  input  logic               id_halt,
  input  logic               ex_mem_read,
  input  logic [REG_W-1:0]   ex_write_reg,
  input  logic               ex_reg_write,
  input  logic               ex_branch_taken,
  input  logic               imem_stall,
  input  logic               dmem_stall,
  input  logic               wb_halt,
  output logic               pc_write,
  output logic               if_id_write,
  output logic               if_id_flush,
  output logic               id_ex_write,
  output logic               id_ex_flush,
  output logic               ex_mem_write,
  output logic               mem_wb_bubble,
  output logic               halted,
  output logic [STALL_W-1:0] stall_count
);

  state_e             state_q, state_d;
  logic [DCNT_W-1:0]  drain_cnt_q, drain_cnt_d;
  logic [STALL_W-1:0] stall_count_q, stall_count_d;
  pipe_ctrl_t         ctrl_c;
  logic               load_use_c;

  loaduse_detect u_loaduse_detect (
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_rs_used   (id_rs_used),
    .id_rt_used   (id_rt_used),
    .ex_mem_read  (ex_mem_read),
    .ex_write_reg (ex_write_reg),
    .ex_reg_write (ex_reg_write),
    .hazard_c     (load_use_c)
  );

  // Next state, drain counter and controls; causes resolved by fixed priority.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    ctrl_c      = CTRL_NORMAL;
    unique case (state_q)
      RUN: begin
        if (dmem_stall) begin
          ctrl_c = CTRL_FREEZE;
        end else if (ex_branch_taken) begin
          ctrl_c.if_id_flush = 1'b1;
          ctrl_c.id_ex_flush = 1'b1;
        end else if (load_use_c) begin
          ctrl_c.pc_write    = 1'b0;
          ctrl_c.if_id_write = 1'b0;
          ctrl_c.id_ex_flush = 1'b1;
        end else if (id_halt) begin
          // HALT moves on to EX; stop fetching behind it.
          ctrl_c.pc_write = 1'b0;
          state_d         = DRAIN;
          drain_cnt_d     = DRAIN_DEPTH;
        end else if (imem_stall) begin
          ctrl_c.pc_write    = 1'b0;
          ctrl_c.if_id_flush = 1'b1;
        end
      end
      DRAIN: begin
        // Branches are ignored: nothing younger than HALT is worth keeping.
        if (dmem_stall) begin
          ctrl_c = CTRL_FREEZE;
        end else begin
          ctrl_c.pc_write    = 1'b0;
          ctrl_c.if_id_flush = 1'b1;
          if (drain_cnt_q != '0) drain_cnt_d = drain_cnt_q - DCNT_W'(1);
        end
        if (wb_halt) state_d = HALTED;
      end
      HALTED: begin
        ctrl_c = CTRL_FREEZE;
      end
      default: begin
        state_d = RUN;
      end
    endcase
    if (rst) ctrl_c = CTRL_RESET;
  end

  // Saturating count of RUN-state cycles that hold the PC.
  always_comb begin
    stall_count_d = stall_count_q;
    if ((state_q == RUN) && !ctrl_c.pc_write && (stall_count_q != STALL_MAX))
      stall_count_d = stall_count_q + STALL_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      drain_cnt_q   <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      drain_cnt_q   <= drain_cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign pc_write      = ctrl_c.pc_write;
  assign if_id_write   = ctrl_c.if_id_write;
  assign if_id_flush   = ctrl_c.if_id_flush;
  assign id_ex_write   = ctrl_c.id_ex_write;
  assign id_ex_flush   = ctrl_c.id_ex_flush;
  assign ex_mem_write  = ctrl_c.ex_mem_write;
  assign mem_wb_bubble = ctrl_c.mem_wb_bubble;
  assign halted        = (state_q == HALTED) && !rst;
  assign stall_count   = stall_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a vector table for the RUN-state priority
// logic plus hand sequences for stalls, draining, halt, reset and saturation.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  id_rs, id_rt, ex_write_reg;
  logic        id_rs_used, id_rt_used, id_halt, ex_mem_read, ex_reg_write;
  logic        ex_branch_taken, imem_stall, dmem_stall, wb_halt;
  logic        pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
  logic        ex_mem_write, mem_wb_bubble, halted;
  logic [15:0] stall_count;

  int n_pass = 0;
  int n_total = 0;

  // Control encodings {pc, if_id_w, if_id_f, id_ex_w, id_ex_f, ex_mem_w, bubble}
  localparam logic [6:0] C_NORM   = 7'b1101010;
  localparam logic [6:0] C_FREEZE = 7'b0000001;
  localparam logic [6:0] C_BRANCH = 7'b1111110;
  localparam logic [6:0] C_LDUSE  = 7'b0001110;
  localparam logic [6:0] C_IMEM   = 7'b0111010;
  localparam logic [6:0] C_HALT   = 7'b0101010;
  localparam logic [6:0] C_DRAIN  = 7'b0111010;
  localparam logic [6:0] C_RESET  = 7'b0010101;

  hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_halt(id_halt),
    .ex_mem_read(ex_mem_read), .ex_write_reg(ex_write_reg),
    .ex_reg_write(ex_reg_write), .ex_branch_taken(ex_branch_taken),
    .imem_stall(imem_stall), .dmem_stall(dmem_stall), .wb_halt(wb_halt),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_write(id_ex_write), .id_ex_flush(id_ex_flush),
    .ex_mem_write(ex_mem_write), .mem_wb_bubble(mem_wb_bubble),
    .halted(halted), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] rs;
    logic [2:0] rt;
    logic       rs_used;
    logic       rt_used;
    logic       mem_read;
    logic [2:0] wr;
    logic       reg_write;
    logic       branch;
    logic       imem;
    logic       dmem;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[14];

  function automatic logic [6:0] ctrl_now();
    return {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
            ex_mem_write, mem_wb_bubble};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic clear_inputs();
    id_rs = 3'd0; id_rt = 3'd0; id_rs_used = 1'b0; id_rt_used = 1'b0;
    id_halt = 1'b0; ex_mem_read = 1'b0; ex_write_reg = 3'd0;
    ex_reg_write = 1'b0; ex_branch_taken = 1'b0; imem_stall = 1'b0;
    dmem_stall = 1'b0; wb_halt = 1'b0;
  endtask

  task automatic set_loaduse();
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_write_reg = 3'd2;
    id_rs = 3'd2; id_rs_used = 1'b1; id_rt = 3'd1; id_rt_used = 1'b1;
  endtask

  // Inputs change 1 time unit after a rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    #2;
    check("reset_ctrl", 16'(ctrl_now()), 16'(C_RESET));
    check("reset_halted", 16'(halted), 16'd0);
    check("reset_stall_count", stall_count, 16'd0);
    @(negedge clk);
    rst = 1'b0;

    //            rs    rt    rsu   rtu   mr    wr    rw    br    im    dm    exp
    vecs[0]  = '{3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM};
    vecs[1]  = '{3'd2, 3'd1, 1'b1, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, C_LDUSE};
    vecs[2]  = '{3'd1, 3'd5, 1'b1, 1'b1, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, C_LDUSE};
    vecs[3]  = '{3'd2, 3'd1, 1'b0, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, C_NORM};
    vecs[4]  = '{3'd2, 3'd1, 1'b1, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM};
    vecs[5]  = '{3'd3, 3'd4, 1'b1, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, C_NORM};
    vecs[6]  = '{3'd2, 3'd1, 1'b1, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, C_NORM};
    vecs[7]  = '{3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, C_IMEM};
    vecs[8]  = '{3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, C_BRANCH};
    vecs[9]  = '{3'd2, 3'd1, 1'b1, 1'b1, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, C_BRANCH};
    vecs[10] = '{3'd2, 3'd1, 1'b1, 1'b1, 1'b1, 3'd2, 1'b1, 1'b1, 1'b1, 1'b1, C_FREEZE};
    vecs[11] = '{3'd2, 3'd1, 1'b1, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0, C_LDUSE};
    vecs[12] = '{3'd0, 3'd7, 1'b1, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, C_LDUSE};
    vecs[13] = '{3'd6, 3'd6, 1'b1, 1'b0, 1'b1, 3'd6, 1'b1, 1'b0, 1'b1, 1'b0, C_LDUSE};

    foreach (vecs[i]) begin
      next_cycle();
      id_rs = vecs[i].rs; id_rt = vecs[i].rt;
      id_rs_used = vecs[i].rs_used; id_rt_used = vecs[i].rt_used;
      ex_mem_read = vecs[i].mem_read; ex_write_reg = vecs[i].wr;
      ex_reg_write = vecs[i].reg_write; ex_branch_taken = vecs[i].branch;
      imem_stall = vecs[i].imem; dmem_stall = vecs[i].dmem;
      @(negedge clk);
      check($sformatf("vec%0d_ctrl", i), 16'(ctrl_now()), 16'(vecs[i].exp));
    end

    // Load then dependent add: one bubble, one stall cycle.
    do_reset();
    next_cycle();
    set_loaduse();
    @(negedge clk);
    check("lu_ctrl", 16'(ctrl_now()), 16'(C_LDUSE));
    next_cycle();
    clear_inputs();
    @(negedge clk);
    check("lu_after_ctrl", 16'(ctrl_now()), 16'(C_NORM));
    check("lu_stall_count", stall_count, 16'd1);

    // Branch beats IMEM stall; IMEM seen next cycle.
    next_cycle();
    ex_branch_taken = 1'b1; imem_stall = 1'b1;
    @(negedge clk);
    check("br_imem_ctrl", 16'(ctrl_now()), 16'(C_BRANCH));
    next_cycle();
    ex_branch_taken = 1'b0;
    @(negedge clk);
    check("br_then_imem_ctrl", 16'(ctrl_now()), 16'(C_IMEM));

    // Four DMEM freeze cycles over a load-use hazard, then the bubble.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      set_loaduse();
      dmem_stall = 1'b1;
      @(negedge clk);
      check($sformatf("dm_freeze%0d", k), 16'(ctrl_now()), 16'(C_FREEZE));
    end
    next_cycle();
    dmem_stall = 1'b0;
    @(negedge clk);
    check("dm_then_lu", 16'(ctrl_now()), 16'(C_LDUSE));
    next_cycle();
    clear_inputs();
    @(negedge clk);
    check("dm_lu_stall_count", stall_count, 16'd5);

    // HALT, drain (branch ignored, DMEM freezes), then halted forever.
    do_reset();
    next_cycle();
    id_halt = 1'b1;
    @(negedge clk);
    check("halt_run_ctrl", 16'(ctrl_now()), 16'(C_HALT));
    next_cycle();
    id_halt = 1'b0; ex_branch_taken = 1'b1;
    @(negedge clk);
    check("drain1_ctrl", 16'(ctrl_now()), 16'(C_DRAIN));
    check("drain1_halted", 16'(halted), 16'd0);
    next_cycle();
    ex_branch_taken = 1'b0; dmem_stall = 1'b1;
    @(negedge clk);
    check("drain2_freeze", 16'(ctrl_now()), 16'(C_FREEZE));
    next_cycle();
    dmem_stall = 1'b0; wb_halt = 1'b1;
    @(negedge clk);
    check("drain3_ctrl", 16'(ctrl_now()), 16'(C_DRAIN));
    check("drain3_halted", 16'(halted), 16'd0);
    for (int k = 0; k < 20; k++) begin
      next_cycle();
      wb_halt = 1'b0;
      imem_stall = k[0]; ex_branch_taken = k[1]; id_halt = k[2];
      @(negedge clk);
      check($sformatf("halted%0d", k), 16'(halted), 16'd1);
      check($sformatf("halted%0d_ctrl", k), 16'(ctrl_now()), 16'(C_FREEZE));
    end
    check("halt_stall_count", stall_count, 16'd1);

    // Asynchronous reset from HALTED, between edges.
    #2;
    rst = 1'b1;
    #1;
    check("rst_halted_flag", 16'(halted), 16'd0);
    check("rst_halted_ctrl", 16'(ctrl_now()), 16'(C_RESET));
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();

    // Asynchronous reset mid-DRAIN, then normal running.
    next_cycle();
    id_halt = 1'b1;
    next_cycle();
    id_halt = 1'b0;
    @(negedge clk);
    check("pre_rst_drain_ctrl", 16'(ctrl_now()), 16'(C_DRAIN));
    #2;
    rst = 1'b1;
    #1;
    check("rst_drain_ctrl", 16'(ctrl_now()), 16'(C_RESET));
    check("rst_drain_halted", 16'(halted), 16'd0);
    check("rst_drain_stall", stall_count, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    next_cycle();
    @(negedge clk);
    check("post_rst_ctrl", 16'(ctrl_now()), 16'(C_NORM));
    next_cycle();
    @(negedge clk);
    check("post_rst_ctrl2", 16'(ctrl_now()), 16'(C_NORM));
    check("post_rst_stall", stall_count, 16'd0);

    // Saturation: hold IMEM stall until the counter pins at all-ones.
    next_cycle();
    imem_stall = 1'b1;
    repeat (65534) @(posedge clk);
    @(negedge clk);
    check("sat_fffe", stall_count, 16'hFFFE);
    @(negedge clk);
    check("sat_ffff", stall_count, 16'hFFFF);
    repeat (5) @(negedge clk);
    check("sat_hold", stall_count, 16'hFFFF);
    check("sat_ctrl", 16'(ctrl_now()), 16'(C_IMEM));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
